// File: rtl/pwm_pkg.sv
// Shared constants for the PWM sequencer: widths, reset timing, cfg address map, FSM encoding.
// Pure declarations, no logic.
package pwm_pkg;

  localparam int CNT_W = 32;

  localparam logic [CNT_W-1:0] DEF_PERIOD = 32'd10000;
  localparam logic [CNT_W-1:0] DEF_DUTY   = 32'd5000;
  localparam logic [CNT_W-1:0] MIN_PERIOD = 32'd2;

  localparam int ADDR_PERIOD = 0;
  localparam int ADDR_DUTY0  = 1;

  localparam logic [1:0] S_STOP        = 2'd0;
  localparam logic [1:0] S_RUN         = 2'd1;
  localparam logic [1:0] S_WAIT_COMMIT = 2'd2;

  // A one-clock period would leave no room for a low phase, so the floor is two.
  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM channel: registered compare of the shared counter against this channel's active duty.
// One clock latency from cnt; no backpressure.
module pwm_compare_ch
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] duty_act,
  input  logic [CNT_W-1:0] cnt,
  input  logic             running,
  output logic             pwm
);

  // duty==0 never matches and duty>=period always matches, so both extremes fall out of one compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= running && (cnt < duty_act);
    end
  end

endmodule

// File: rtl/pwm_sequencer.sv
// Multi-channel PWM with shared period counter and shadow/active config banks swapped at period wrap.
// Outputs lag cnt by one clock; cfg_ready drops while a commit is pending.
module pwm_sequencer
  import pwm_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int ADDR_W = $clog2(N_CH + 1)
) (
  input  logic              in_10MHz,
  input  logic              RESET_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_data,
  input  logic              cfg_commit,
  output logic              period_start,
  output logic              busy,
  output logic [N_CH-1:0]   PWM_out
);

  logic [1:0]                 state;
  logic [1:0]                 state_nxt;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           period_sh;
  logic [CNT_W-1:0]           period_act;
  logic [N_CH-1:0][CNT_W-1:0] duty_sh;
  logic [N_CH-1:0][CNT_W-1:0] duty_act;
  logic                       wr_acc;
  logic                       commit_acc;
  logic                       running;
  logic                       wrap;
  logic                       transfer;
  logic                       out_en;

  assign cfg_ready    = ~busy;
  assign wr_acc       = cfg_valid && cfg_ready;
  assign commit_acc   = cfg_commit && cfg_ready;
  assign running      = (state != S_STOP);
  assign wrap         = running && (cnt == period_act - CNT_W'(1));
  // Banks only swap at a wrap or while stopped, so cnt can never sit above a shrunken period.
  assign transfer     = busy && ((state == S_STOP) || wrap);
  assign period_start = running && (cnt == '0);
  // Gating with enable makes outputs drop on the same edge the FSM enters STOP.
  assign out_en       = running && enable;

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = S_STOP;
    end else begin
      case (state)
        S_STOP:        state_nxt = commit_acc ? S_WAIT_COMMIT : S_RUN;
        S_RUN:         state_nxt = commit_acc ? S_WAIT_COMMIT : S_RUN;
        S_WAIT_COMMIT: state_nxt = transfer ? S_RUN : S_WAIT_COMMIT;
        default:       state_nxt = S_STOP;
      endcase
    end
  end

  always_ff @(posedge in_10MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      state <= S_STOP;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge in_10MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      cnt <= '0;
    end else if (!running || !enable || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge in_10MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      busy <= 1'b0;
    end else if (commit_acc) begin
      busy <= 1'b1;
    end else if (transfer) begin
      busy <= 1'b0;
    end
  end

  // Writes are blocked while busy, so the shadow bank is stable for the whole pending window.
  always_ff @(posedge in_10MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      period_sh <= DEF_PERIOD;
      duty_sh   <= {N_CH{DEF_DUTY}};
    end else if (wr_acc) begin
      if (cfg_addr == ADDR_W'(ADDR_PERIOD)) begin
        period_sh <= clamp_period(cfg_data);
      end
      for (int k = 0; k < N_CH; k++) begin
        if (cfg_addr == ADDR_W'(ADDR_DUTY0 + k)) begin
          duty_sh[k] <= cfg_data;
        end
      end
    end
  end

  always_ff @(posedge in_10MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      period_act <= DEF_PERIOD;
      duty_act   <= {N_CH{DEF_DUTY}};
    end else if (transfer) begin
      period_act <= period_sh;
      duty_act   <= duty_sh;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_compare_ch u_ch (
      .clk      (in_10MHz),
      .rst_n    (RESET_n),
      .duty_act (duty_act[g]),
      .cnt      (cnt),
      .running  (out_en),
      .pwm      (PWM_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed scenarios plus a random phase, every cycle compared with a period/position reference model.
module tb_pwm_sequencer;
  import pwm_pkg::*;

  localparam int N_CH   = 4;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [CNT_W-1:0]  cfg_data = '0;
  logic              cfg_commit = 1'b0;
  logic              period_start;
  logic              busy;
  logic [N_CH-1:0]   PWM_out;

  int n_assert = 0;
  int n_fail   = 0;

  pwm_sequencer #(.N_CH(N_CH), .ADDR_W(ADDR_W)) dut (
    .in_10MHz     (clk),
    .RESET_n      (rst_n),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_commit   (cfg_commit),
    .period_start (period_start),
    .busy         (busy),
    .PWM_out      (PWM_out)
  );

  always #5 clk = ~clk;

  // Reference: position within the running period, active/shadow settings, and a pending-commit flag.
  bit              m_run;
  bit              m_pend;
  int unsigned     m_pos;
  int unsigned     m_per_a;
  int unsigned     m_per_s;
  int unsigned     m_duty_a [N_CH];
  int unsigned     m_duty_s [N_CH];
  logic [N_CH-1:0] m_pwm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_pos = 0; m_pwm = '0;
    m_per_a = DEF_PERIOD; m_per_s = DEF_PERIOD;
    for (int k = 0; k < N_CH; k++) begin
      m_duty_a[k] = DEF_DUTY; m_duty_s[k] = DEF_DUTY;
    end
  endtask

  task automatic model_edge();
    logic [N_CH-1:0] pn;
    bit rdy, wr, cm, at_end, xfer;
    rdy    = !m_pend;
    wr     = cfg_valid && rdy;
    cm     = cfg_commit && rdy;
    at_end = m_run && (m_pos == m_per_a - 1);
    for (int k = 0; k < N_CH; k++) pn[k] = m_run && enable && (m_pos < m_duty_a[k]);
    xfer = m_pend && (!m_run || at_end);
    if (xfer) begin
      m_per_a = m_per_s;
      for (int k = 0; k < N_CH; k++) m_duty_a[k] = m_duty_s[k];
    end
    if (wr) begin
      if (cfg_addr == 0) m_per_s = (cfg_data < 2) ? 2 : cfg_data;
      else if (cfg_addr <= N_CH) m_duty_s[cfg_addr - 1] = cfg_data;
    end
    m_pos  = (!enable || !m_run || at_end) ? 0 : m_pos + 1;
    m_run  = enable;
    m_pend = cm ? 1'b1 : (xfer ? 1'b0 : m_pend);
    m_pwm  = pn;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("pwm_out", PWM_out, m_pwm);
    chk("period_start", period_start, m_run && (m_pos == 0));
    chk("busy", busy, m_pend);
    chk("cfg_ready", cfg_ready, !m_pend);
  endtask

  task automatic write(input int addr, input int data, input bit with_commit);
    cfg_valid = 1; cfg_addr = ADDR_W'(addr); cfg_data = CNT_W'(data); cfg_commit = with_commit;
    step();
    cfg_valid = 0; cfg_commit = 0;
  endtask

  task automatic commit();
    cfg_commit = 1;
    step();
    cfg_commit = 0;
  endtask

  task automatic wait_pstart(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = period_start;
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    int hi0, hi1, hiall, ps;

    // 1: reset values, then default 10000/5000 timing
    model_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_pwm", PWM_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_pstart", period_start, 0);
    @(negedge clk) rst_n = 1;
    enable = 1;
    wait_pstart("t1_first_start", 5);
    hiall = 0; ps = 0;
    for (int i = 1; i <= 10000; i++) begin
      step();
      if (PWM_out == 4'hF) hiall++;
      if (period_start) ps++;
    end
    chk("t1_high_cycles", hiall, 5000);
    chk("t1_start_count", ps, 1);
    chk("t1_start_spacing", period_start, 1);

    // 2: period 10 / duty0 3 committed mid-period, write and commit in one cycle
    repeat (3) step();
    write(0, 10, 0);
    write(1, 3, 1);
    chk("t2_busy_set", busy, 1);
    chk("t2_ready_low", cfg_ready, 0);
    wait_pstart("t2_wrap", 10001);
    chk("t2_busy_clear", busy, 0);
    hi0 = 0; hi1 = 0; ps = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      hi0 += PWM_out[0]; hi1 += PWM_out[1]; ps += period_start;
    end
    chk("t2_duty0_high", hi0, 6);
    chk("t2_duty1_high", hi1, 20);
    chk("t2_start_count", ps, 2);

    // 3: duty 0 never high, duty == period always high
    write(1, 0, 0);
    write(2, 10, 0);
    write(0, 10, 1);
    wait_pstart("t3_wrap", 30);
    hi0 = 0; hi1 = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      hi0 += PWM_out[0]; hi1 += PWM_out[1];
    end
    chk("t3_duty0_never", hi0, 0);
    chk("t3_duty1_always", hi1, 20);

    // 4: period 1 clamps to 2; out-of-range address discarded
    write(0, 1, 0);
    write(N_CH + 1, 7, 0);
    commit();
    wait_pstart("t4_wrap", 30);
    ps = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      ps += period_start;
    end
    chk("t4_clamped_starts", ps, 5);
    chk("t4_duties_kept", PWM_out, 4'b1110);

    // 5: enable dropped with a commit pending
    write(0, 10, 1);
    enable = 0;
    step();
    chk("t5_stop_pwm", PWM_out, 0);
    chk("t5_stop_pstart", period_start, 0);
    step();
    chk("t5_busy_done", busy, 0);
    enable = 1;
    step();
    chk("t5_restart_start", period_start, 1);
    ps = 0; hi1 = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      ps += period_start; hi1 += PWM_out[1];
    end
    chk("t5_new_period", ps, 1);
    chk("t5_duty1_high", hi1, 10);

    // 6: asynchronous reset at cnt=4
    repeat (4) step();
    #2 rst_n = 0;
    #1;
    chk("t6_async_pwm", PWM_out, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_pstart", period_start, 0);
    model_reset();
    @(negedge clk) rst_n = 1;
    wait_pstart("t6_restart", 5);
    hiall = 0;
    for (int i = 1; i <= 10000; i++) begin
      step();
      if (PWM_out == 4'hF) hiall++;
    end
    chk("t6_defaults_high", hiall, 5000);

    // Random config traffic, small periods so commits and wraps happen often
    write(0, 8, 1);
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 49) != 0);
      cfg_valid  = $urandom_range(0, 1) != 0;
      cfg_addr   = ADDR_W'($urandom_range(0, 7));
      cfg_data   = CNT_W'($urandom_range(0, 15));
      cfg_commit = ($urandom_range(0, 19) == 0);
      step();
    end
    cfg_valid = 0; cfg_commit = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
